// File: rtl/vid_out_phy_pkg.sv
// Shared definitions for the video PMOD transmit PHY: link states, default
// blanking fill bytes and the nibble-to-pad-word mapping.
package vid_out_phy_pkg;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_PRE = 2'd1,
        ST_RUN = 2'd2
    } vid_state_e;

    localparam logic [7:0] FILL_A_DEF = 8'h80;
    localparam logic [7:0] FILL_B_DEF = 8'h10;
    localparam int         PAD_W      = 5;

    // Pad word is {even parity, nibble}; flip inverts parity for error injection.
    function automatic logic [4:0] pad_word(input logic [3:0] nib, input logic flip);
        return {(^nib) ^ flip, nib};
    endfunction

endpackage

// File: rtl/vid_out_phy_fifo.sv
// Single-clock byte FIFO with combinational head read, occupancy output and
// a synchronous flush that empties it in one edge.
module vid_out_phy_fifo
    import vid_out_phy_pkg::*;
#(
    parameter int DEPTH = 16
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [7:0]             i_data,
    input  logic                   i_pop,
    output logic [7:0]             o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push & ~o_full & ~i_flush;
    assign w_pop  = i_pop & ~o_empty & ~i_flush;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: ;
            endcase
        end
    end

    // DEPTH is a power of two, so the level MSB alone means full.
    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_level[AW];
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/vid_out_phy.sv
// Transmit PHY for the analog video PMOD link: FIFO-fed byte stream with
// blanking fill, split into two parity-protected nibbles on DDR pads.
module vid_out_phy
    import vid_out_phy_pkg::*;
#(
    parameter int         DEPTH   = 16,
    parameter int         PRE_LEN = 16,
    parameter logic [7:0] FILL_A  = FILL_A_DEF,
    parameter logic [7:0] FILL_B  = FILL_B_DEF
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   active,
    input  logic                   err_inj,
    output logic                   stat_underflow,
    input  logic                   stat_clr,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [4:0]             pad_data,
    output logic                   pad_clk
);
    localparam int CW = $clog2(PRE_LEN + 1);

    vid_state_e    r_state;
    logic [CW-1:0] r_pre_cnt;
    logic          r_fill_b;
    logic          r_err_pend;
    logic          r_stat_underflow;
    logic          r_out_vld;
    logic          r_out_err;
    logic [7:0]    r_out_byte;
    logic [4:0]    r_iob_rise;
    logic [4:0]    r_iob_fall;
    logic          r_iob_clk_en;

    logic [7:0]    w_head;
    logic [7:0]    w_fill_byte;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_fill_run;
    logic          w_err;

    assign in_ready       = (r_state != ST_OFF) & ~w_full;
    assign w_push         = in_valid & in_ready;
    assign w_pop          = active & (r_state == ST_RUN) & ~w_empty;
    assign w_fill_run     = active & (r_state == ST_RUN) & w_empty;
    assign w_fill_byte    = r_fill_b ? FILL_B : FILL_A;
    assign w_err          = r_err_pend | err_inj;
    assign stat_underflow = r_stat_underflow;

    vid_out_phy_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (~active),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    // While active, exactly one byte (FIFO head or fill) enters the output reg per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_OFF;
            r_pre_cnt        <= '0;
            r_fill_b         <= 1'b0;
            r_err_pend       <= 1'b0;
            r_stat_underflow <= 1'b0;
            r_out_vld        <= 1'b0;
            r_out_err        <= 1'b0;
            r_out_byte       <= '0;
        end else begin
            if (!active) begin
                r_state    <= ST_OFF;
                r_pre_cnt  <= '0;
                r_fill_b   <= 1'b0;
                r_out_vld  <= 1'b0;
                r_err_pend <= w_err;
            end else begin
                r_out_vld  <= 1'b1;
                r_out_byte <= w_pop ? w_head : w_fill_byte;
                r_out_err  <= w_err;
                r_err_pend <= 1'b0;
                r_fill_b   <= ~w_pop & ~r_fill_b;
                case (r_state)
                    ST_OFF: begin
                        r_state   <= ST_PRE;
                        r_pre_cnt <= CW'(1);
                    end
                    ST_PRE: begin
                        if (r_pre_cnt == CW'(PRE_LEN - 1))
                            r_state <= ST_RUN;
                        else
                            r_pre_cnt <= r_pre_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (stat_clr)
                r_stat_underflow <= 1'b0;
            else if (w_fill_run)
                r_stat_underflow <= 1'b1;
        end
    end

    // Behavioral DDR output registers: rise word drives the high phase, fall word the low phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iob_rise   <= '0;
            r_iob_fall   <= '0;
            r_iob_clk_en <= 1'b0;
        end else begin
            r_iob_clk_en <= r_out_vld;
            r_iob_rise   <= r_out_vld ? pad_word(r_out_byte[3:0], r_out_err) : '0;
            r_iob_fall   <= r_out_vld ? pad_word(r_out_byte[7:4], 1'b0) : '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PAD_W; gi++) begin : g_pad_data
            assign pad_data[gi] = clk ? r_iob_rise[gi] : r_iob_fall[gi];
        end
    endgenerate

    assign pad_clk = ~clk & r_iob_clk_en;

endmodule

// File: tb/tb_vid_out_phy.sv
// Scoreboard bench for vid_out_phy: stimulus queues expected pad words, a
// capture-side monitor decodes the DDR pads and checks fills and data.
module tb_vid_out_phy;
    localparam int         P_DEPTH = 16;
    localparam int         P_PRE   = 24;
    localparam logic [7:0] F_A     = 8'h80;
    localparam logic [7:0] F_B     = 8'h10;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [7:0]               in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     active;
    logic                     err_inj;
    logic                     stat_underflow;
    logic                     stat_clr;
    logic [$clog2(P_DEPTH):0] fifo_level;
    logic [4:0]               pad_data;
    logic                     pad_clk;

    typedef struct packed {
        logic [7:0] b;
        logic [4:0] er;
        logic [4:0] ef;
        logic       err;
        logic       chain;
        logic       tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // low nibble i with high nibble 3: rise = {parity(i), i}
    logic [4:0] rise_tbl [16] = '{5'h00, 5'h11, 5'h12, 5'h03, 5'h14, 5'h05, 5'h06, 5'h17,
                                  5'h18, 5'h09, 5'h0A, 5'h1B, 5'h0C, 5'h1D, 5'h1E, 5'h0F};

    vid_out_phy #(
        .DEPTH   (P_DEPTH),
        .PRE_LEN (P_PRE),
        .FILL_A  (F_A),
        .FILL_B  (F_B)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .active         (active),
        .err_inj        (err_inj),
        .stat_underflow (stat_underflow),
        .stat_clr       (stat_clr),
        .fifo_level     (fifo_level),
        .pad_data       (pad_data),
        .pad_clk        (pad_clk)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, req, cyc);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic [4:0] er, input logic [4:0] ef,
                        input logic err, input logic chain, input logic tag,
                        input logic track, output int acc_cyc);
        logic acc;
        acc      = 1'b0;
        acc_cyc  = -1;
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !acc; k++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        chk("push_accept", 32'(acc), 32'd1);
        if (acc) begin
            acc_cyc = cyc;
            if (track)
                sb.push_back('{b: b, er: er, ef: ef, err: err, chain: chain, tag: tag});
        end
    endtask

    // Capture-side monitor
    logic [4:0] m_rise, m_fall;
    logic       m_clk_hi, m_clk_lo, m_verr, m_live = 1'b0, m_seen_data = 1'b0;
    logic [7:0] m_b, m_fill_next = F_A;
    exp_t       m_e;
    int         m_rise_cyc, m_on_cyc = -1, m_fills = 0, m_pre_fills = -1, m_tag_cyc = -1;

    initial begin : monitor
        forever begin
            @(posedge clk);
            #2;
            m_rise     = pad_data;
            m_clk_hi   = pad_clk;
            m_rise_cyc = cyc;
            @(negedge clk);
            #2;
            m_fall   = pad_data;
            m_clk_lo = pad_clk;
            chk("pad_clk_high_phase", 32'(m_clk_hi), 32'd0);
            if (m_clk_lo) begin
                m_b    = {m_fall[3:0], m_rise[3:0]};
                m_verr = (^m_rise) | (^m_fall);
                if (!m_live) begin
                    m_live      = 1'b1;
                    m_on_cyc    = m_rise_cyc;
                    m_fills     = 0;
                    m_seen_data = 1'b0;
                    m_fill_next = F_A;
                end
                if (m_b == m_fill_next && (sb.size() == 0 || sb[0].b != m_b)) begin
                    if (sb.size() != 0)
                        chk("fill_gap_in_burst", 32'(sb[0].chain), 32'd0);
                    chk("fill_vid_err", 32'(m_verr), 32'd0);
                    m_fill_next = (m_b == F_A) ? F_B : F_A;
                    m_fills++;
                end else if (sb.size() == 0) begin
                    chk("unexpected_byte", 32'(m_b), 32'(m_fill_next));
                end else begin
                    m_e = sb.pop_front();
                    chk("rx_byte", 32'(m_b), 32'(m_e.b));
                    chk("rx_rise_word", 32'(m_rise), 32'(m_e.er));
                    chk("rx_fall_word", 32'(m_fall), 32'(m_e.ef));
                    chk("rx_vid_err", 32'(m_verr), 32'(m_e.err));
                    if (m_e.tag)
                        m_tag_cyc = m_rise_cyc;
                    if (!m_seen_data) begin
                        m_seen_data = 1'b1;
                        m_pre_fills = m_fills;
                    end
                    m_fill_next = F_A;
                    $display("rx byte %02h rise=%05b fall=%05b vid_err=%0d cyc=%0d",
                             m_b, m_rise, m_fall, m_verr, m_rise_cyc);
                end
            end else begin
                chk("idle_pad_rise", 32'(m_rise), 32'd0);
                chk("idle_pad_fall", 32'(m_fall), 32'd0);
                m_live = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int e_cyc, acc;
        in_data  = '0;
        in_valid = 1'b0;
        active   = 1'b0;
        err_inj  = 1'b0;
        stat_clr = 1'b0;

        repeat (3) tick();
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_stat", 32'(stat_underflow), 32'd0);
        chk("reset_level", 32'(fifo_level), 32'd0);
        chk("reset_pad_data", 32'(pad_data), 32'd0);
        chk("reset_pad_clk", 32'(pad_clk), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: enable with no input, PRE window then RUN underflow
        active = 1'b1;
        tick();
        e_cyc = cyc;
        for (int k = 0; k < P_PRE; k++) begin
            chk("stat_in_pre", 32'(stat_underflow), 32'd0);
            tick();
        end
        chk("stat_after_run", 32'(stat_underflow), 32'd1);
        chk("pad_clk_start", 32'(m_on_cyc), 32'(e_cyc + 1));
        repeat (3) tick();

        // 2: back-to-back bytes into empty FIFO
        send(8'h00, 5'h00, 5'h00, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        e_cyc = acc;
        send(8'hFF, 5'h0F, 5'h0F, 1'b0, 1'b1, 1'b0, 1'b1, acc);
        send(8'h5A, 5'h0A, 5'h05, 1'b0, 1'b1, 1'b0, 1'b1, acc);
        send(8'hA5, 5'h05, 5'h0A, 1'b0, 1'b1, 1'b0, 1'b1, acc);
        repeat (6) tick();
        chk("first_byte_latency", 32'(m_tag_cyc), 32'(e_cyc + 2));

        // 4: err_inj hits 01 as it leaves; 02 is clean
        send(8'h01, 5'h01, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1, acc);
        err_inj = 1'b1;
        send(8'h02, 5'h12, 5'h00, 1'b0, 1'b1, 1'b0, 1'b1, acc);
        err_inj = 1'b0;
        repeat (5) tick();

        // 6: stat_clr wins over same-cycle fill
        chk("stat_before_clr", 32'(stat_underflow), 32'd1);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("stat_clr_wins", 32'(stat_underflow), 32'd0);
        tick();
        chk("stat_reset_by_fill", 32'(stat_underflow), 32'd1);

        // 5: drop active with bytes queued in PRE
        active = 1'b0;
        repeat (2) tick();
        active = 1'b1;
        tick();
        for (int i = 0; i < 5; i++)
            send(8'h41 + 8'(i), 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        chk("level_queued", 32'(fifo_level), 32'd5);
        active = 1'b0;
        tick();
        chk("off_level", 32'(fifo_level), 32'd0);
        chk("off_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("inflight_pad_clk", 32'(pad_clk), 32'd1);
        tick();
        chk("off_pad_data_rise", 32'(pad_data), 32'd0);
        @(negedge clk);
        #1;
        chk("off_pad_clk", 32'(pad_clk), 32'd0);
        chk("off_pad_data_fall", 32'(pad_data), 32'd0);
        tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("stat_cleared_off", 32'(stat_underflow), 32'd0);

        // 3: fill the FIFO during a replayed PRE window
        active = 1'b1;
        tick();
        e_cyc = cyc;
        for (int i = 0; i < P_DEPTH; i++)
            send(8'h30 + 8'(i), rise_tbl[i], 5'h03, 1'b0, (i != 0), 1'b0, 1'b1, acc);
        chk("level_full", 32'(fifo_level), 32'(P_DEPTH));
        in_data  = 8'h99;
        in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("in_ready_full", 32'(in_ready), 32'd0);
            tick();
            chk("level_held", 32'(fifo_level), 32'(P_DEPTH));
        end
        in_valid = 1'b0;
        chk("stat_replay_pre", 32'(stat_underflow), 32'd0);
        for (int k = 0; k < 200 && sb.size() != 0; k++)
            tick();
        repeat (3) tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("replay_pre_fills", 32'(m_pre_fills), 32'(P_PRE));
        chk("replay_pad_clk_start", 32'(m_on_cyc), 32'(e_cyc + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
